// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver: hex or decimal display of a
// latched value, sequential shift-add-3 BCD conversion, blanking and overflow dashes.
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int IN_WIDTH     = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] num,
  input  logic                load,
  input  logic                hex_mode,
  input  logic                blank_lz,
  output logic                busy,
  output logic [DIGITS-1:0]   Anode,
  output logic [6:0]          LED_out
);
  // state   | meaning
  // IDLE    | waiting for load; display register holds the last result
  // CONVERT | shift-add-3 running, one input bit per cycle, MSB first

  localparam int BW   = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = $clog2(IN_WIDTH + 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  localparam logic [IDXW-1:0] SCAN_LAST = IDXW'(DIGITS - 1);

  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [IDXW-1:0]         scan_q, scan_d;
  logic [0:0]              state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic                    ovf_acc_q, ovf_acc_d;
  logic                    blank_pend_q, blank_pend_d;
  logic [BW-1:0]           disp_code_q, disp_code_d;
  logic                    disp_ovf_q, disp_ovf_d;
  logic                    disp_blank_q, disp_blank_d;

  logic [BW+IN_WIDTH-1:0]  num_wide;
  logic [BW-1:0]           bcd_adj;
  logic [BW-1:0]           bcd_shift;
  logic                    carry_out;

  assign num_wide = {{BW{1'b0}}, num};
  assign busy     = (state_q == ST_CONVERT);

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // one double-dabble step: adjust digits >= 5, then shift the next input bit in
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    carry_out = bcd_adj[BW-1];
    bcd_shift = {bcd_adj[BW-2:0], shift_q[IN_WIDTH-1]};
  end

  always_comb begin
    presc_d      = presc_q + 1'b1;
    scan_d       = scan_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    ovf_acc_d    = ovf_acc_q;
    blank_pend_d = blank_pend_q;
    disp_code_d  = disp_code_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;

    if (presc_q == '1) scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (hex_mode) begin
            disp_code_d  = num_wide[BW-1:0];
            disp_ovf_d   = |num_wide[BW+IN_WIDTH-1:BW];
            disp_blank_d = blank_lz;
          end else begin
            state_d      = ST_CONVERT;
            cnt_d        = CNTW'(IN_WIDTH);
            shift_d      = num;
            bcd_d        = '0;
            ovf_acc_d    = 1'b0;
            blank_pend_d = blank_lz;
          end
        end
      end
      default: begin
        bcd_d     = bcd_shift;
        shift_d   = shift_q << 1;
        ovf_acc_d = ovf_acc_q | carry_out;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d      = ST_IDLE;
          disp_code_d  = bcd_shift;
          disp_ovf_d   = ovf_acc_q | carry_out;
          disp_blank_d = blank_pend_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      scan_q       <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      bcd_q        <= '0;
      ovf_acc_q    <= 1'b0;
      blank_pend_q <= 1'b0;
      disp_code_q  <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      scan_q       <= scan_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      ovf_acc_q    <= ovf_acc_d;
      blank_pend_q <= blank_pend_d;
      disp_code_q  <= disp_code_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  int         sel;
  logic [3:0] cur_code;
  logic       cur_lz;
  logic [DIGITS-1:0] lz;
  logic       zero_above;

  // lz[k] marks digits that are zero together with every digit above them
  always_comb begin
    sel        = DIGITS - 1 - int'(scan_q);
    lz         = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (disp_code_q[4*k +: 4] == 4'd0);
      lz[k]      = zero_above;
    end
    Anode    = '1;
    cur_code = '0;
    cur_lz   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == sel) begin
        Anode[k] = 1'b0;
        cur_code = disp_code_q[4*k +: 4];
        cur_lz   = lz[k] && (k != 0);
      end
    end
    if (disp_ovf_q)                  LED_out = 7'b1111110;
    else if (disp_blank_q && cur_lz) LED_out = 7'b1111111;
    else                             LED_out = seg_decode(cur_code);
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a 4-digit and a 3-digit scanner share stimulus; expected
// digit patterns come from an arithmetic model and are checked every cycle.
module tb_seven_segment_scanner;
  localparam int IW = 13;
  localparam int RB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [IW-1:0] num = '0;
  logic          busy4, busy3;
  logic [3:0]    anode4;
  logic [2:0]    anode3;
  logic [6:0]    led4, led3;

  always #5 clk = ~clk;

  seven_segment_scanner #(.DIGITS(4), .IN_WIDTH(IW), .REFRESH_BITS(RB)) u_dut4 (
    .clk(clk), .rst(rst), .num(num), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy4), .Anode(anode4), .LED_out(led4));

  seven_segment_scanner #(.DIGITS(3), .IN_WIDTH(IW), .REFRESH_BITS(RB)) u_dut3 (
    .clk(clk), .rst(rst), .num(num), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy3), .Anode(anode3), .LED_out(led3));

  int checks = 0;
  int errors = 0;
  logic [48:0] exp_q[$];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [6:0] seg(int d);
    case (d)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // digit k (0 = rightmost) occupies bits [7k+6:7k]
  function automatic logic [55:0] disp_model(int nd, int v, bit hx, bit bl);
    int         dg[8];
    bit         ovf;
    bit         lead;
    int         p;
    logic [55:0] r;
    r = '1;
    p = 1;
    if (hx) begin
      ovf = (v >> (4 * nd)) != 0;
      for (int k = 0; k < nd; k++) dg[k] = (v >> (4 * k)) & 15;
    end else begin
      for (int k = 0; k < nd; k++) p = p * 10;
      ovf = (v >= p);
      p = 1;
      for (int k = 0; k < nd; k++) begin
        dg[k] = (v / p) % 10;
        p = p * 10;
      end
    end
    for (int k = 0; k < nd; k++) begin
      lead = 1'b1;
      for (int j = k; j < nd; j++) if (dg[j] != 0) lead = 1'b0;
      if (ovf)                        r[7*k +: 7] = 7'b1111110;
      else if (bl && lead && k != 0)  r[7*k +: 7] = 7'b1111111;
      else                            r[7*k +: 7] = seg(dg[k]);
    end
    return r;
  endfunction

  // ---------------- monitor: timing model + per-cycle display check ----------
  logic [27:0] cur4;
  logic [20:0] cur3;
  int  cyc = 0;
  bit  cyc_valid = 1'b0;
  int  busy_cnt = 0;
  bit  p_rst = 1'b0, p_load = 1'b0, p_hex = 1'b0;

  task automatic commit();
    logic [48:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_commit", 1, 0);
    end else begin
      e    = exp_q.pop_front();
      cur4 = e[48:21];
      cur3 = e[20:0];
    end
  endtask

  always @(negedge clk) begin
    logic [55:0] m;
    logic [3:0]  ea4;
    logic [2:0]  ea3;
    int          d4, d3;
    if (p_rst) begin
      cyc       = 0;
      cyc_valid = 1'b1;
      busy_cnt  = 0;
      m         = disp_model(4, 0, 1'b0, 1'b0);
      cur4      = m[27:0];
      m         = disp_model(3, 0, 1'b0, 1'b0);
      cur3      = m[20:0];
    end else begin
      cyc++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) commit();
      end else if (p_load) begin
        if (p_hex) commit();
        else       busy_cnt = IW;
      end
    end
    if (cyc_valid) begin
      d4 = 3 - ((cyc >> RB) % 4);
      d3 = 2 - ((cyc >> RB) % 3);
      ea4 = '1;  ea4[d4] = 1'b0;
      ea3 = '1;  ea3[d3] = 1'b0;
      chk("busy4", int'(busy4), int'(busy_cnt > 0));
      chk("busy3", int'(busy3), int'(busy_cnt > 0));
      chk("anode4", int'(anode4), int'(ea4));
      chk("anode3", int'(anode3), int'(ea3));
      chk("led4", int'(led4), int'(cur4[7*d4 +: 7]));
      chk("led3", int'(led3), int'(cur3[7*d3 +: 7]));
    end
    p_rst  = rst;
    p_load = load;
    p_hex  = hex_mode;
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(int v, bit h, bit b);
    logic [55:0] m4, m3;
    m4 = disp_model(4, v, h, b);
    m3 = disp_model(3, v, h, b);
    exp_q.push_back({m4[27:0], m3[20:0]});
  endtask

  task automatic do_load(int v, bit h, bit b);
    @(posedge clk); #1;
    num = IW'(v); hex_mode = h; blank_lz = b; load = 1'b1;
    push_exp(v, h, b);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic pulse_dropped_load(int v, bit h);
    @(posedge clk); #1;
    num = IW'(v); hex_mode = h; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("commit_pending", exp_q.size(), 0);
    repeat (24) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (24) @(posedge clk);

    do_load(1234, 1'b0, 1'b0);   wait_idle();
    do_load(8191, 1'b0, 1'b0);   wait_idle();
    do_load('h1ABC, 1'b1, 1'b0); wait_idle();
    do_load(1000, 1'b0, 1'b0);   wait_idle();
    do_load(7, 1'b0, 1'b1);      wait_idle();
    do_load(0, 1'b0, 1'b1);      wait_idle();
    do_load(405, 1'b0, 1'b1);    wait_idle();
    do_load('h00A, 1'b1, 1'b1);  wait_idle();

    // a load during conversion is dropped
    do_load(5678, 1'b0, 1'b0);
    @(posedge clk);
    pulse_dropped_load(1111, 1'b0);
    wait_idle();

    // reset mid-conversion aborts it
    do_load(4321, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (24) @(posedge clk);

    for (int it = 0; it < 40; it++) begin
      int v, k;
      bit h, b;
      v = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 8191));
      h = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      do_load(v, h, b);
      if (!h && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 10);
        repeat (k) @(posedge clk);
        pulse_dropped_load($urandom_range(0, 8191), 1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised multiplexed seven-segment display driver: the next generation of the four-digit decimal driver. It scans `DIGITS` common-anode digits and converts a latched binary value to BCD with a sequential shift-add-3 engine, one bit per cycle. It also provides a hexadecimal mode, leading-zero blanking, an overflow indication, and a load/busy handshake. It sits between datapath debug values and the board's anode/segment pins.

## Interface
- `DIGITS`, 4: number of digits scanned (2..8).
- `IN_WIDTH`, 13: width of the binary input (1..27).
- `REFRESH_BITS`, 18: each digit is lit for 2^REFRESH_BITS cycles.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `num`  in  IN_WIDTH  unsigned value, sampled on an accepted `load`.
- `load`  in  1  one-cycle request to capture `num`, `hex_mode` and `blank_lz`.
- `hex_mode`  in  1  1 = show hex nibbles; 0 = show decimal.
- `blank_lz`  in  1  1 = blank leading zeros.
- `busy`  out  1  decimal conversion in progress; `load` is ignored while high.
- `Anode`  out  DIGITS  active-low digit enables. `Anode[DIGITS-1]` is the leftmost (most significant) digit.
- `LED_out`  out  7  active-low segments, bit6 = a … bit0 = g.

## Operation
- **Capture.** `load` is accepted when `busy`=0 and `rst`=0. `num` and both mode bits are latched.
- **Hex mode.** Digit k shows `num[4k+3:4k]`, zero-extended. The display register updates on the accepting edge. `busy` stays 0.
- **Decimal mode.** `busy` goes to 1.
  - The FSM has two states, IDLE and CONVERT.
  - CONVERT runs exactly IN_WIDTH cycles. Each cycle it first adds 3 to every BCD digit that is ≥5, then shifts in the next `num` bit, MSB first.
- **Overflow.** An overflow flag sets under either condition:
  - Decimal: a 1 is shifted out of the top BCD digit.
  - Hex: `num` has a nonzero bit at position ≥ 4·DIGITS.
- **Display register commit.** The register is updated atomically on the last CONVERT edge. The old value is shown throughout the conversion. It stores per digit a 4-bit code plus the overflow flag.
- **Overflow display.** When overflow is set, every digit shows a dash, 1111110. Blanking does not apply.
- **Leading-zero blanking.** When blanking is latched, all zero digits above the highest nonzero digit show 1111111. The rightmost digit is never blanked, so a value of 0 shows "0".
- **Segment codes.**
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100
  - 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100
  - A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000
  - Codes 10–15 cannot occur in decimal mode.
- **Scanning.**
  - A REFRESH_BITS-wide prescaler wraps to 0.
  - On each wrap the scan index advances 0→DIGITS-1, then back to 0. This works for non-power-of-2 `DIGITS`.
  - Index i enables `Anode[DIGITS-1-i]` (low) with all other anodes high. Scanning runs left to right.
- **Outputs.** `Anode` and `LED_out` are combinational from the scan index and display register. They are glitch-free only at register granularity.

## Timing
- **Reset.**
  - Prescaler, scan index, BCD engine and display register all clear. The FSM goes to IDLE.
  - `busy`=0, `Anode` = 0 at bit DIGITS-1 and 1 elsewhere (4'b0111), `LED_out`=0000001.
  - Blanking and overflow are 0, so the display shows all "0".
- **Decimal load at edge T.** `busy`=1 after T through the edge T+IN_WIDTH. That edge clears `busy` and commits the display register. New digits are visible in the cycle after it.
- **Hex load at edge T.** New digits are visible in the cycle after T.
- **Load while busy.** Dropped, with no queueing and no effect on the running conversion.
- **`rst` with `load` in the same cycle.** `rst` wins.
- **`rst` mid-conversion.** Aborts the conversion. The display returns to the reset state on the next cycle.
- The scan never stalls for loads or conversions.

## Test plan
Use `DIGITS`=4, `IN_WIDTH`=13, `REFRESH_BITS`=2 unless stated.
- **Reset.** Assert `rst` 2 cycles → `busy`=0, `Anode`=0111, `LED_out`=0000001. Anodes then cycle 0111, 1011, 1101, 1110, each for 4 cycles, all showing "0".
- **Decimal conversion.** `load` with `num`=1234, `hex_mode`=0 → `busy` high exactly 13 cycles. Digits show 1001111, 0010010, 0000110, 1001100 on anodes 0111..1110. `load`=8191 → "8191".
- **Hex mode.** `num`=0x1ABC, `hex_mode`=1 → "1AbC", `busy` never rises. A repeat with `DIGITS`=3 → all three digits show 1111110.
- **Decimal overflow and blanking.** With `DIGITS`=3, decimal 1000 → "---". With `blank_lz`=1: `num`=7 → 1111111, 1111111, 1111111, 0001111; `num`=0 → blanks then 0000001; `num`=405 → blank, 4, 0, 5.
- **Handshake.** `load` 5678 then `load` 1111 on cycle 3 of the conversion → the display ends at "5678". `rst` at cycle 6 of a conversion → `busy`=0 next cycle and the display shows reset "0000".
